// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   MULDIV_XLEN      default operand/result width
//   MULDIV_OP_*      RV32M funct3 encodings
//   muldiv_state_t   sequencer states IDLE/CALC/FIX/DONE
package muldiv_pkg;

  localparam int unsigned MULDIV_XLEN = 32;

  localparam logic [2:0] MULDIV_OP_MUL    = 3'b000;
  localparam logic [2:0] MULDIV_OP_MULH   = 3'b001;
  localparam logic [2:0] MULDIV_OP_MULHSU = 3'b010;
  localparam logic [2:0] MULDIV_OP_MULHU  = 3'b011;
  localparam logic [2:0] MULDIV_OP_DIV    = 3'b100;
  localparam logic [2:0] MULDIV_OP_DIVU   = 3'b101;
  localparam logic [2:0] MULDIV_OP_REM    = 3'b110;
  localparam logic [2:0] MULDIV_OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_iter_dp.sv
// Iterative datapath: one radix-2 shift-add (multiply) or restoring
// subtract (divide) step per enabled cycle. No control state.
//   clk, rst   clock, async active-high reset
//   load       initialise: hi=0, lo=load_lo, m=load_m
//   step       perform one iteration
//   div        1 = divide step, 0 = multiply step
//   load_lo    multiplier (mul) or dividend (div) magnitude
//   load_m     multiplicand (mul) or divisor (div) magnitude
//   hi, lo     mul: 2*XLEN product {hi,lo}; div: remainder hi, quotient lo
module muldiv_iter_dp #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            div,
  input  logic [XLEN-1:0] load_lo,
  input  logic [XLEN-1:0] load_m,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic [XLEN-1:0] m;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_diff;

  // div_shift can reach 2^(XLEN+1)-1, so the compare is done at XLEN+1 bits;
  // when it succeeds the difference is always below the divisor and fits XLEN.
  always_comb begin
    mul_sum   = {1'b0, hi} + {1'b0, m};
    div_shift = {hi, lo[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, m});
    div_diff  = XLEN'(div_shift - {1'b0, m});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
      m  <= '0;
    end else if (load) begin
      hi <= '0;
      lo <= load_lo;
      m  <= load_m;
    end else if (step) begin
      if (div) begin
        if (div_ge) begin
          hi <= div_diff;
          lo <= {lo[XLEN-2:0], 1'b1};
        end else begin
          hi <= div_shift[XLEN-1:0];
          lo <= {lo[XLEN-2:0], 1'b0};
        end
      end else begin
        if (lo[0]) begin
          {hi, lo} <= {mul_sum, lo[XLEN-1:1]};
        end else begin
          {hi, lo} <= {1'b0, hi, lo[XLEN-1:1]};
        end
      end
    end
  end

endmodule

// File: rtl/muldiv_controller.sv
// Multi-cycle RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU sequencer.
// Runs magnitudes through muldiv_iter_dp for XLEN steps, then applies
// sign correction and selects the result word.
//   clk       core clock, rising edge
//   rst       asynchronous active-high reset
//   start     request, sampled only in IDLE
//   flush     aborts any operation in flight (overrides start)
//   op        funct3 operation select
//   operand1  rs1 (multiplicand / dividend)
//   operand2  rs2 (multiplier / divisor)
//   busy      high in CALC and FIX
//   done      one-cycle pulse with result valid
//   result    selected result word, held until the next done
module muldiv_controller
  import muldiv_pkg::*;
#(
  parameter  int unsigned XLEN  = MULDIV_XLEN,
  localparam int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   state;
  logic [CNT_W-1:0] counter;
  logic [2:0]       op_q;
  logic             s1_q;
  logic             s2_q;

  // Accept-time decode
  logic            accept;
  logic            op_is_div;
  logic            op1_signed;
  logic            op2_signed;
  logic            s1;
  logic            s2;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_res;

  // Datapath interface
  logic            dp_load;
  logic            dp_step;
  logic [XLEN-1:0] dp_load_lo;
  logic [XLEN-1:0] dp_load_m;
  logic [XLEN-1:0] dp_hi;
  logic [XLEN-1:0] dp_lo;

  // Sign correction and result select
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    accept     = (state == ST_IDLE) && start && !flush;
    op_is_div  = op[2];
    op1_signed = (op == MULDIV_OP_MULH) || (op == MULDIV_OP_MULHSU) ||
                 (op == MULDIV_OP_DIV)  || (op == MULDIV_OP_REM);
    op2_signed = (op == MULDIV_OP_MULH) || (op == MULDIV_OP_DIV) ||
                 (op == MULDIV_OP_REM);
    s1         = op1_signed && operand1[XLEN-1];
    s2         = op2_signed && operand2[XLEN-1];
    abs1       = s1 ? -operand1 : operand1;
    abs2       = s2 ? -operand2 : operand2;
    div_zero   = op_is_div && (operand2 == '0);
    div_ovf    = ((op == MULDIV_OP_DIV) || (op == MULDIV_OP_REM)) &&
                 (operand1 == INT_MIN) && (operand2 == '1);
    special    = div_zero || div_ovf;
    // op[1] separates REM/REMU from DIV/DIVU
    if (div_zero) begin
      special_res = op[1] ? operand1 : '1;
    end else begin
      special_res = op[1] ? '0 : operand1;
    end
    dp_load    = accept && !special;
    dp_step    = (state == ST_CALC) && !flush;
    dp_load_lo = op_is_div ? abs1 : abs2;
    dp_load_m  = op_is_div ? abs2 : abs1;
  end

  muldiv_iter_dp #(
    .XLEN(XLEN)
  ) u_dp (
    .clk     (clk),
    .rst     (rst),
    .load    (dp_load),
    .step    (dp_step),
    .div     (op_q[2]),
    .load_lo (dp_load_lo),
    .load_m  (dp_load_m),
    .hi      (dp_hi),
    .lo      (dp_lo)
  );

  always_comb begin
    prod     = {dp_hi, dp_lo};
    prod_fix = (s1_q ^ s2_q) ? -prod : prod;
    quot_fix = (s1_q ^ s2_q) ? -dp_lo : dp_lo;
    rem_fix  = s1_q ? -dp_hi : dp_hi;
    case (op_q)
      MULDIV_OP_MUL:                                      fix_res = prod_fix[XLEN-1:0];
      MULDIV_OP_MULH, MULDIV_OP_MULHSU, MULDIV_OP_MULHU:  fix_res = prod_fix[2*XLEN-1:XLEN];
      MULDIV_OP_DIV, MULDIV_OP_DIVU:                      fix_res = quot_fix;
      MULDIV_OP_REM, MULDIV_OP_REMU:                      fix_res = rem_fix;
      default:                                            fix_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      counter <= '0;
      op_q    <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else if (flush) begin
      // A done already on the outputs this cycle stays visible; only the
      // next state is forced.
      state   <= ST_IDLE;
      counter <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (accept) begin
            op_q <= op;
            s1_q <= s1;
            s2_q <= s2;
            if (special) begin
              result <= special_res;
              done   <= 1'b1;
              state  <= ST_DONE;
            end else begin
              counter <= CNT_W'(XLEN);
              busy    <= 1'b1;
              state   <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          counter <= counter - 1'b1;
          if (counter == CNT_W'(1)) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          result <= fix_res;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
